// File: rtl/volatility_rd_sched_pkg.sv
// Shared types and widths for the volatility read scheduler.
// Widths are derived from the default region geometry below; the top-level
// parameters default to the same values.
package vol_sched_pkg;

  localparam int NUM_STOCKS_D  = 4;
  localparam int BUFFER_SIZE_D = 20;
  localparam int DATA_WIDTH_D  = 32;

  localparam int STOCK_W = $clog2(NUM_STOCKS_D);
  localparam int ADDR_W  = $clog2(NUM_STOCKS_D * BUFFER_SIZE_D);
  localparam int IDX_W   = $clog2(BUFFER_SIZE_D + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/volatility_rd_sched_arbiter.sv
// Combinational round-robin: picks the first pending stock after the
// last-granted one, wrapping around the stock index space.
module vol_rr_arbiter
  import vol_sched_pkg::*;
#(
  parameter int NUM_STOCKS = NUM_STOCKS_D
) (
  input  logic [NUM_STOCKS-1:0] i_pending,
  input  logic [STOCK_W-1:0]    i_last,
  output logic                  o_grant_valid,
  output logic [STOCK_W-1:0]    o_grant_id
);

  int w_idx;

  // Scan from last+1 upward; first pending hit wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    w_idx         = 0;
    for (int k = 1; k <= NUM_STOCKS; k++) begin
      w_idx = (int'(i_last) + k) % NUM_STOCKS;
      if (!o_grant_valid && i_pending[STOCK_W'(w_idx)]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = STOCK_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/volatility_rd_sched.sv
// Volatility read scheduler: mirrors write pointers/fill per stock, grants
// pending stocks round-robin and streams the most recent window of buffer
// addresses (oldest first) for the granted stock.
// Optional macro VOL_SCHED_PERF_EN adds o_stall_cycles (backpressure count).
//
// state | meaning
// IDLE  | waiting for a pending stock; grants one when available
// SETUP | snapshot write pointer and read count, compute start index
// READ  | stream addresses, hold while downstream is not ready
// DONE  | one-cycle completion pulse
module volatility_rd_sched
  import vol_sched_pkg::*;
#(
  parameter int NUM_STOCKS  = NUM_STOCKS_D,
  parameter int BUFFER_SIZE = BUFFER_SIZE_D,
  parameter int DATA_WIDTH  = DATA_WIDTH_D
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr_valid,
  input  logic [STOCK_W-1:0]    i_wr_stock_id,
  input  logic [DATA_WIDTH-1:0] i_window_size,
  input  logic                  i_rd_ready,
  output logic [ADDR_W-1:0]     o_rd_address,
  output logic                  o_rd_valid,
  output logic                  o_rd_last,
  output logic [STOCK_W-1:0]    o_stock_id,
  output logic                  o_busy,
  output logic                  o_done
`ifdef VOL_SCHED_PERF_EN
  , output logic [DATA_WIDTH-1:0] o_stall_cycles
`endif
);

  localparam logic [IDX_W-1:0]  L_BS    = IDX_W'(BUFFER_SIZE);
  localparam logic [IDX_W-1:0]  L_BS_M1 = IDX_W'(BUFFER_SIZE - 1);
  localparam logic [ADDR_W-1:0] L_BS_A  = ADDR_W'(BUFFER_SIZE);

  state_t                r_state, w_next;
  logic [IDX_W-1:0]      r_wr_ptr [NUM_STOCKS];
  logic [IDX_W-1:0]      r_fill   [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] r_pending, w_set_mask, w_clr_mask;
  logic [STOCK_W-1:0]    r_last, r_grant, w_grant_id;
  logic                  w_grant_valid, w_grant_now, w_accept;
  logic [IDX_W-1:0]      r_idx, r_remain, w_win, w_count;
  logic [ADDR_W-1:0]     w_start_sum, w_start;

  vol_rr_arbiter #(.NUM_STOCKS(NUM_STOCKS)) u_arb (
    .i_pending     (r_pending),
    .i_last        (r_last),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_grant_now = (r_state == IDLE) && w_grant_valid;
  assign w_accept    = (r_state == READ) && i_rd_ready;

  // Window clamp (0 or oversize means a full region) and wrapped start index.
  always_comb begin
    if (i_window_size == '0 || i_window_size > DATA_WIDTH'(BUFFER_SIZE))
      w_win = L_BS;
    else
      w_win = i_window_size[IDX_W-1:0];
    w_count     = (r_fill[r_grant] < w_win) ? r_fill[r_grant] : w_win;
    w_start_sum = ADDR_W'(r_wr_ptr[r_grant]) + L_BS_A - ADDR_W'(w_count);
    w_start     = (w_start_sum >= L_BS_A) ? w_start_sum - L_BS_A : w_start_sum;
  end

  // Mirror write-side pointer and saturating fill for every stock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        r_wr_ptr[s] <= '0;
        r_fill[s]   <= '0;
      end
    end else if (i_wr_valid) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        if (i_wr_stock_id == STOCK_W'(s)) begin
          r_wr_ptr[s] <= (r_wr_ptr[s] == L_BS_M1) ? '0 : r_wr_ptr[s] + 1'b1;
          if (r_fill[s] != L_BS)
            r_fill[s] <= r_fill[s] + 1'b1;
        end
      end
    end
  end

  // Set wins over clear so a write racing its own grant is rescheduled.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_wr_valid)
      w_set_mask[i_wr_stock_id] = 1'b1;
    if (w_grant_now)
      w_clr_mask[w_grant_id] = 1'b1;
  end

  // Pending vector and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending <= '0;
      r_last    <= STOCK_W'(NUM_STOCKS - 1);
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
      if (w_grant_now)
        r_last <= w_grant_id;
    end
  end

  // Sequence datapath: granted stock, current index, beats remaining.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_grant  <= '0;
      r_idx    <= '0;
      r_remain <= '0;
    end else begin
      if (w_grant_now)
        r_grant <= w_grant_id;
      if (r_state == SETUP) begin
        r_idx    <= IDX_W'(w_start);
        r_remain <= w_count;
      end else if (w_accept) begin
        r_idx    <= (r_idx == L_BS_M1) ? '0 : r_idx + 1'b1;
        r_remain <= r_remain - 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next = SETUP;
      SETUP:   w_next = READ;
      READ:    if (w_accept && r_remain == IDX_W'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode; address and last are forced low outside READ.
  always_comb begin
    o_rd_valid   = (r_state == READ);
    o_rd_last    = (r_state == READ) && (r_remain == IDX_W'(1));
    o_rd_address = '0;
    if (r_state == READ)
      o_rd_address = ADDR_W'(r_grant) * L_BS_A + ADDR_W'(r_idx);
    o_busy     = (r_state == SETUP) || (r_state == READ);
    o_done     = (r_state == DONE);
    o_stock_id = r_grant;
  end

`ifdef VOL_SCHED_PERF_EN
  logic [DATA_WIDTH-1:0] r_stall;

  // Saturating count of valid-but-not-ready cycles; cleared only by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_stall <= '0;
    else if (o_rd_valid && !i_rd_ready && r_stall != '1)
      r_stall <= r_stall + 1'b1;
  end

  assign o_stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_volatility_rd_sched.sv
// Self-checking bench for volatility_rd_sched. A transaction-level model
// (pending set, fill/pointer per stock, expected address queue per grant)
// predicts every cycle's outputs; directed scenarios add hand-derived lists.
module tb_volatility_rd_sched;
  import vol_sched_pkg::*;

  localparam int NS = 4;
  localparam int BS = 20;
  localparam int P_FREE = 0, P_SETUP = 1, P_READ = 2, P_DONE = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_valid = 1'b0;
  logic [1:0]        wr_id = '0;
  logic [31:0]       win = 32'd8;
  logic              rd_ready = 1'b0;
  logic [ADDR_W-1:0] o_rd_address;
  logic              o_rd_valid, o_rd_last, o_busy, o_done;
  logic [1:0]        o_stock_id;
`ifdef VOL_SCHED_PERF_EN
  logic [31:0]       o_stall;
`endif

  volatility_rd_sched dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_wr_valid(wr_valid),
    .i_wr_stock_id(wr_id), .i_window_size(win), .i_rd_ready(rd_ready),
    .o_rd_address(o_rd_address), .o_rd_valid(o_rd_valid), .o_rd_last(o_rd_last),
    .o_stock_id(o_stock_id), .o_busy(o_busy), .o_done(o_done)
`ifdef VOL_SCHED_PERF_EN
    , .o_stall_cycles(o_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model
  int      m_ptr [NS];
  int      m_fill[NS];
  bit [NS-1:0] m_pend;
  int      m_last, m_g, m_phase, m_stall;
  int      m_q[$];

  // observations
  int cap[$];
  int seq_stock[$];
  int exp_q[$];
  int done_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin m_ptr[s] = 0; m_fill[s] = 0; end
    m_pend = '0; m_last = NS - 1; m_g = 0; m_phase = P_FREE; m_stall = 0;
    m_q.delete();
  endtask

  task automatic model_update();
    int w, n, st, s;
    bit found;
    case (m_phase)
      P_FREE: begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          s = (m_last + k) % NS;
          if (!found && m_pend[s]) begin found = 1'b1; m_g = s; end
        end
        if (found) begin m_pend[m_g] = 1'b0; m_last = m_g; m_phase = P_SETUP; end
      end
      P_SETUP: begin
        w  = (win == 0 || win > BS) ? BS : int'(win);
        n  = (m_fill[m_g] < w) ? m_fill[m_g] : w;
        st = (m_ptr[m_g] + BS - n) % BS;
        m_q.delete();
        for (int k = 0; k < n; k++) m_q.push_back(m_g * BS + (st + k) % BS);
        m_phase = P_READ;
      end
      P_READ: begin
        if (rd_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_phase = P_DONE;
        end else begin
          m_stall++;
        end
      end
      default: m_phase = P_FREE;
    endcase
    if (wr_valid) begin
      m_ptr[wr_id] = (m_ptr[wr_id] + 1) % BS;
      if (m_fill[wr_id] < BS) m_fill[wr_id]++;
      m_pend[wr_id] = 1'b1;
    end
  endtask

  // One clock: compare at negedge, observe beats, advance model at posedge.
  task automatic step();
    @(negedge clk);
    check("rd_valid", o_rd_valid, m_phase == P_READ);
    check("busy", o_busy, m_phase == P_SETUP || m_phase == P_READ);
    check("done", o_done, m_phase == P_DONE);
    check("rd_last", o_rd_last, m_phase == P_READ && m_q.size() == 1);
    if (m_phase == P_READ) check("rd_address", o_rd_address, m_q[0]);
    if (m_phase == P_SETUP || m_phase == P_READ) check("stock_id", o_stock_id, m_g);
`ifdef VOL_SCHED_PERF_EN
    check("stall_cycles", o_stall, m_stall);
`endif
    if (o_rd_valid && rd_ready) begin
      cap.push_back(int'(o_rd_address));
      if (o_rd_last) seq_stock.push_back(int'(o_stock_id));
    end
    if (o_done) done_cnt++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    while ((m_phase != P_FREE || m_pend != '0) && b > 0) begin step(); b--; end
    check("drain_settled", (m_phase == P_FREE && m_pend == '0), 1);
    step(); step();
  endtask

  task automatic write_n(input int stock, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1; wr_id = 2'(stock);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic check_cap(input string tag);
    check($sformatf("%s_len", tag), cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), cap[i], exp_q[i]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, o_rd_valid, 0);
    check({tag, "_last"}, o_rd_last, 0);
    check({tag, "_addr"}, o_rd_address, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_stock"}, o_stock_id, 0);
`ifdef VOL_SCHED_PERF_EN
    check({tag, "_stall"}, o_stall, 0);
`endif
  endtask

  task automatic clear_obs();
    cap.delete(); seq_stock.delete(); exp_q.delete(); done_cnt = 0;
  endtask

  initial begin
    int saved, b, st;

    // Reset state
    model_reset();
    #2 rst_n = 1'b0;
    #2 check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill and read: writes race the first grant, so stock 1 is read twice,
    // first with the two samples present at snapshot, then all five.
    clear_obs();
    rd_ready = 1'b1; win = 32'd8;
    write_n(1, 5);
    drain(100);
    foreach (exp_q[i]) ;
    exp_q.push_back(20); exp_q.push_back(21);
    for (int k = 20; k <= 24; k++) exp_q.push_back(k);
    check_cap("fill_read");
    check("fill_read_done_pulses", done_cnt, 2);

    // Wrap-around: final sequence after 23 writes to stock 2
    clear_obs();
    win = 32'd6;
    write_n(2, 23);
    drain(400);
    check("wrap_enough_beats", cap.size() >= 6, 1);
    if (cap.size() >= 6) begin
      st = cap.size() - 6;
      check("wrap_a0", cap[st],     57);
      check("wrap_a1", cap[st + 1], 58);
      check("wrap_a2", cap[st + 2], 59);
      check("wrap_a3", cap[st + 3], 40);
      check("wrap_a4", cap[st + 4], 41);
      check("wrap_a5", cap[st + 5], 42);
    end
    check("wrap_last_stock", seq_stock[$], 2);

    // Backpressure: stall three cycles after two beats
    clear_obs();
    write_n(2, 1);
    rd_ready = 1'b1;
    b = 20;
    while (cap.size() < 2 && b > 0) begin step(); b--; end
    check("bp_reached_two_beats", cap.size(), 2);
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_addr", o_rd_address, 40);
      check("bp_hold_valid", o_rd_valid, 1);
    end
    drain(50);
    exp_q.push_back(58); exp_q.push_back(59);
    for (int k = 40; k <= 43; k++) exp_q.push_back(k);
    check_cap("backpressure");
`ifdef VOL_SCHED_PERF_EN
    check("bp_stall_count", o_stall, 3);
`endif

    // Round-robin: 0 active, then 3 and 0 become pending -> 3 before 0
    clear_obs();
    rd_ready = 1'b0;
    write_n(0, 1);
    step(); step();
    write_n(3, 1);
    write_n(0, 1);
    drain(100);
    check("rr_seq_count", seq_stock.size(), 3);
    if (seq_stock.size() == 3) begin
      check("rr_first", seq_stock[0], 0);
      check("rr_second", seq_stock[1], 3);
      check("rr_third", seq_stock[2], 0);
    end
    exp_q.push_back(0); exp_q.push_back(60); exp_q.push_back(0); exp_q.push_back(1);
    check_cap("rr");

    // Write to the active stock during READ: snapshot kept, then re-grant
    clear_obs();
    win = 32'd8; rd_ready = 1'b0;
    write_n(1, 1);
    step(); step();
    write_n(1, 1);
    drain(100);
    for (int k = 20; k <= 25; k++) exp_q.push_back(k);
    for (int k = 20; k <= 26; k++) exp_q.push_back(k);
    check_cap("wr_during_read");
    check("wr_during_read_seqs", seq_stock.size(), 2);

    // Clamp: window 0, 100 and a large value with upper bits set all give 20
    clear_obs(); win = 32'd0; write_n(2, 1); drain(100);
    for (int k = 0; k < 20; k++) exp_q.push_back(40 + (5 + k) % 20);
    check_cap("clamp_zero");
    clear_obs(); win = 32'd100; write_n(2, 1); drain(100);
    for (int k = 0; k < 20; k++) exp_q.push_back(40 + (6 + k) % 20);
    check_cap("clamp_100");
    clear_obs(); win = 32'h0001_0003; write_n(2, 1); drain(100);
    for (int k = 0; k < 20; k++) exp_q.push_back(40 + (7 + k) % 20);
    check_cap("clamp_wide");

    // Reset mid-READ with several stocks pending
    clear_obs();
    win = 32'd8; rd_ready = 1'b1;
    write_n(2, 1); write_n(0, 1); write_n(1, 1);
    b = 20;
    while (!(m_phase == P_READ && cap.size() >= 2) && b > 0) begin step(); b--; end
    check("rst_reached_read", m_phase, P_READ);
    saved = done_cnt;
    rst_n = 1'b0;
    #1 check_zero_outputs("rst_mid");
    model_reset();
    @(posedge clk); #1;
    check("rst_hold_busy", o_busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (8) step();
    check("rst_no_done", done_cnt, saved);
    check("rst_idle_busy", o_busy, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      wr_valid = ($urandom_range(0, 99) < 40);
      wr_id    = 2'($urandom_range(0, NS - 1));
      rd_ready = ($urandom_range(0, 99) < 70);
      case ($urandom_range(0, 3))
        0: win = 32'd0;
        1: win = 32'($urandom_range(1, 25));
        2: win = 32'h8000_0000 | 32'($urandom);
        default: win = 32'd20;
      endcase
      step();
    end
    drain(800);
    check("final_busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
